fifo_to_ll_gearbox: RTL

- Parametrised successor of the 36-bit-word to 8-bit LocalLink converter.
- Takes packed FIFO words of IN_BYTES data bytes plus sof/eof/occupancy sideband and emits LocalLink beats of OUT_BYTES bytes, most-significant byte first.
- Adds a registered output stage (full throughput, 1-cycle latency), a remainder output for multi-byte beats, and a synchronous clear.
- Sits between the TX packet FIFO and the MAC/LocalLink client.

---
 rtl/gearbox_pkg.sv | 35 +++
 rtl/ll_pipe_reg.sv | 46 ++++
 rtl/fifo_to_ll_gearbox.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gearbox_pkg.sv
// ============================================================================
// Module : gearbox_pkg
// Brief  : Shared sizing helpers and FIFO sideband field offsets for
//          fifo_to_ll_gearbox.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gearbox_pkg;

    // Sideband field offsets, relative to bit IN_BYTES*8 of the FIFO word
    localparam int SOF_BIT_OFS = 0;
    localparam int EOF_BIT_OFS = 1;
    localparam int OCC_OFS     = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int occ_width(input int in_bytes);
        return clog2(in_bytes);
    endfunction

    function automatic int rem_width(input int out_bytes);
        return (clog2(out_bytes) > 1) ? clog2(out_bytes) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ll_pipe_reg.sv
// ============================================================================
// Module : ll_pipe_reg
// Brief  : Single-entry valid/ready register with synchronous clear; accepts
//          a new entry in the same cycle the current one drains.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ll_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_ready = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_to_ll_gearbox.sv
// ============================================================================
// Module : fifo_to_ll_gearbox
// Brief  : Splits packed FIFO words into MSB-first LocalLink beats through a
//          registered output stage. FRAME_CHECK_EN adds a sticky frame_err.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_to_ll_gearbox
    import gearbox_pkg::*;
#(
    parameter  int IN_BYTES  = 4,
    parameter  int OUT_BYTES = 1,
    localparam int OCCW      = occ_width(IN_BYTES),
    localparam int REMW      = rem_width(OUT_BYTES),
    localparam int RATIO     = IN_BYTES / OUT_BYTES,
    localparam int FW        = IN_BYTES * 8 + 2 + OCCW
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic [FW-1:0]          f_data,
    input  logic                   f_src_rdy_i,
    output logic                   f_dst_rdy_o,
    output logic [OUT_BYTES*8-1:0] ll_data,
    output logic [REMW-1:0]        ll_rem,
    output logic                   ll_sof_n,
    output logic                   ll_eof_n,
    output logic                   ll_src_rdy_n,
    input  logic                   ll_dst_rdy_n,
    output logic [7:0]             debug
`ifdef FRAME_CHECK_EN
    ,
    output logic                   frame_err
`endif
);

    localparam int OBW  = clog2(OUT_BYTES);
    localparam int IDXW = clog2(RATIO);
    localparam int DW   = IN_BYTES * 8;
    localparam int OW   = OUT_BYTES * 8;
    localparam int SHW  = OCCW + 3;
    localparam int PW   = OW + 2 + REMW;

    logic [DW-1:0]   w_word;
    logic            w_sof;
    logic            w_eof;
    logic [OCCW-1:0] w_occ;
    logic [OCCW-1:0] w_lastbyte;
    logic [IDXW-1:0] r_beat_idx;
    logic [IDXW-1:0] w_eof_beat;
    logic [IDXW-1:0] w_last_beat;
    logic [IDXW-1:0] w_rev_idx;
    logic [SHW-1:0]  w_base;
    logic [OW-1:0]   w_beat_data;
    logic            w_at_last;
    logic            w_beat_sof;
    logic            w_beat_eof;
    logic [REMW-1:0] w_beat_rem;
    logic            w_can_load;
    logic            w_load;
    logic            w_out_valid;
    logic [PW-1:0]   w_out_payload;

    assign w_word = f_data[DW-1:0];
    assign w_sof  = f_data[DW + SOF_BIT_OFS];
    assign w_eof  = f_data[DW + EOF_BIT_OFS];
    assign w_occ  = f_data[DW + OCC_OFS +: OCCW];

    assign w_lastbyte  = (w_occ == '0) ? OCCW'(IN_BYTES - 1) : (w_occ - OCCW'(1));
    assign w_eof_beat  = IDXW'(w_lastbyte >> OBW);
    assign w_last_beat = w_eof ? w_eof_beat : IDXW'(RATIO - 1);
    assign w_at_last   = (r_beat_idx == w_last_beat);
    assign w_beat_sof  = w_sof & (r_beat_idx == '0);
    assign w_beat_eof  = w_eof & (r_beat_idx == w_eof_beat);

    // Beat 0 is the most significant slice, so index from the top of the word
    assign w_rev_idx   = IDXW'(RATIO - 1) - r_beat_idx;
    assign w_base      = SHW'(w_rev_idx) << (OBW + 3);
    assign w_beat_data = w_word[w_base +: OW];

    generate
        if (OUT_BYTES == 1) begin : g_rem_none
            assign w_beat_rem = '0;
        end else begin : g_rem
            logic [OBW-1:0] w_tail;
            // Truncation to OBW bits gives the modulo: a full last beat reads 0
            assign w_tail     = w_lastbyte[OBW-1:0] + OBW'(1);
            assign w_beat_rem = w_beat_eof ? REMW'(w_tail) : '0;
        end
    endgenerate

    assign w_load      = w_can_load & f_src_rdy_i & ~clear & reset_n;
    assign f_dst_rdy_o = w_load & w_at_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_idx <= '0;
        end else if (clear) begin
            r_beat_idx <= '0;
        end else if (w_load) begin
            r_beat_idx <= w_at_last ? '0 : r_beat_idx + IDXW'(1);
        end
    end

    ll_pipe_reg #(
        .WIDTH (PW)
    ) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (clear),
        .i_valid (w_load),
        .o_ready (w_can_load),
        .i_data  ({w_beat_data, w_beat_sof, w_beat_eof, w_beat_rem}),
        .o_valid (w_out_valid),
        .i_ready (~ll_dst_rdy_n),
        .o_data  (w_out_payload)
    );

    assign ll_data      = w_out_payload[PW-1 -: OW];
    assign ll_sof_n     = ~(w_out_valid & w_out_payload[REMW + 1]);
    assign ll_eof_n     = ~(w_out_valid & w_out_payload[REMW]);
    assign ll_rem       = w_out_payload[REMW-1:0];
    assign ll_src_rdy_n = ~w_out_valid;
    assign debug        = {w_load, w_out_valid, {(6 - IDXW){1'b0}}, r_beat_idx};

`ifdef FRAME_CHECK_EN
    logic r_in_frame;
    logic r_frame_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_frame  <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (clear) begin
            r_in_frame  <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (w_load) begin
            if (w_beat_sof && r_in_frame) r_frame_err <= 1'b1;
            if ((r_beat_idx == '0) && !w_sof && !r_in_frame) r_frame_err <= 1'b1;
            if (w_beat_eof)      r_in_frame <= 1'b0;
            else if (w_beat_sof) r_in_frame <= 1'b1;
        end
    end

    assign frame_err = r_frame_err;
`endif

endmodule

`default_nettype wire
